// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSR file and interrupt/MRET trap sequencer for
// the single-issue RV32 core.
// Ports:
//   clk, rst_n               core clock, async active-low reset
//   instr_valid, pc_in       retiring instruction strobe and its PC
//   csr_op, csr_addr,        CSR access (00 none, 01 RW, 10 RS, 11 RC)
//   csr_wdata
//   is_mret                  retiring instruction is MRET
//   irq                      level-sensitive interrupt lines (bit i -> mip[16+i])
//   csr_rdata, csr_illegal   combinational read data / unimplemented-address flag
//   trap_kill                combinational squash of the retiring instruction
//   redirect, redirect_pc    registered one-cycle PC redirect to fetch
module csr_trap_unit #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     NUM_IRQ     = 4,
  parameter logic [XLEN-1:0] RESET_MTVEC = 32'h0000_0100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  input  logic [XLEN-1:0]    pc_in,
  input  logic [1:0]         csr_op,
  input  logic [11:0]        csr_addr,
  input  logic [XLEN-1:0]    csr_wdata,
  input  logic               is_mret,
  input  logic [NUM_IRQ-1:0] irq,
  output logic [XLEN-1:0]    csr_rdata,
  output logic               csr_illegal,
  output logic               trap_kill,
  output logic               redirect,
  output logic [XLEN-1:0]    redirect_pc
);

  localparam int unsigned     IRQ_LSB  = 16;
  localparam logic [XLEN-1:0] ALIGN4   = ~XLEN'(3);
  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MCYCLEH  = 12'hB80;

  typedef enum logic {S_RUN, S_FLUSH} state_e;

  state_e              state_q, state_d;
  logic                st_mie_q, st_mie_d;
  logic                st_mpie_q, st_mpie_d;
  logic [NUM_IRQ-1:0]  mie_q, mie_d;
  logic [NUM_IRQ-1:0]  mip_q, mip_d;
  logic [XLEN-1:0]     mtvec_q, mtvec_d;
  logic [XLEN-1:0]     mscratch_q, mscratch_d;
  logic [XLEN-1:0]     mepc_q, mepc_d;
  logic [XLEN-1:0]     mcause_q, mcause_d;
  logic [63:0]         mcycle_q, mcycle_d;
  logic                redirect_q, redirect_d;
  logic [XLEN-1:0]     redirect_pc_q, redirect_pc_d;

  logic                csr_impl;
  logic [XLEN-1:0]     wval;
  logic [NUM_IRQ-1:0]  irq_hit;
  logic [3:0]          irq_idx;
  logic [30:0]         cause_code;
  logic [XLEN-1:0]     trap_target;
  logic                pending, in_run, take_trap, do_mret, csr_we;

  // Zero-latency CSR read mux
  always_comb begin
    csr_rdata = '0;
    csr_impl  = 1'b1;
    case (csr_addr)
      A_MSTATUS: begin
        csr_rdata[3] = st_mie_q;
        csr_rdata[7] = st_mpie_q;
      end
      A_MIE:      csr_rdata[IRQ_LSB +: NUM_IRQ] = mie_q;
      A_MTVEC:    csr_rdata = mtvec_q;
      A_MSCRATCH: csr_rdata = mscratch_q;
      A_MEPC:     csr_rdata = mepc_q;
      A_MCAUSE:   csr_rdata = mcause_q;
      A_MIP:      csr_rdata[IRQ_LSB +: NUM_IRQ] = mip_q;
      A_MCYCLE:   csr_rdata = mcycle_q[31:0];
      A_MCYCLEH:  csr_rdata = mcycle_q[63:32];
      default:    csr_impl = 1'b0;
    endcase
  end

  assign csr_illegal = (csr_op != 2'b00) && !csr_impl;

  // Read-modify-write value
  always_comb begin
    case (csr_op)
      2'b01:   wval = csr_wdata;
      2'b10:   wval = csr_rdata | csr_wdata;
      2'b11:   wval = csr_rdata & ~csr_wdata;
      default: wval = csr_rdata;
    endcase
  end

  // Lowest enabled pending line wins; mcause code is 16+i
  always_comb begin
    irq_hit = mip_q & mie_q;
    irq_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_hit[i]) irq_idx = 4'(i);
    end
    cause_code  = 31'(IRQ_LSB) + 31'(irq_idx);
    // Only mode 1 is vectored; modes 2/3 fall back to direct
    trap_target = (mtvec_q[1:0] == 2'b01) ? (mtvec_q & ALIGN4) + (XLEN'(cause_code) << 2)
                                          : (mtvec_q & ALIGN4);
  end

  assign in_run    = (state_q == S_RUN);
  assign pending   = st_mie_q && (|irq_hit);
  assign take_trap = in_run && instr_valid && pending;
  assign do_mret   = in_run && instr_valid && is_mret && !take_trap;
  assign csr_we    = in_run && instr_valid && !take_trap && (csr_op != 2'b00) && csr_impl;
  assign trap_kill = take_trap;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RUN;
    else        state_q <= state_d;
  end

  // FSM next state: FLUSH always lasts exactly one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (take_trap || do_mret) state_d = S_FLUSH;
      S_FLUSH: state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  // FSM outputs: redirect strobe and target
  always_comb begin
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    if (take_trap) begin
      redirect_d    = 1'b1;
      redirect_pc_d = trap_target;
    end else if (do_mret) begin
      redirect_d    = 1'b1;
      redirect_pc_d = mepc_q;
    end
  end

  // CSR next-state: explicit writes, then trap/MRET side effects
  always_comb begin
    st_mie_d   = st_mie_q;
    st_mpie_d  = st_mpie_q;
    mie_d      = mie_q;
    mip_d      = irq;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mcycle_d   = mcycle_q + 64'd1;
    if (csr_we) begin
      case (csr_addr)
        A_MSTATUS: begin
          st_mie_d  = wval[3];
          st_mpie_d = wval[7];
        end
        A_MIE:      mie_d      = wval[IRQ_LSB +: NUM_IRQ];
        A_MTVEC:    mtvec_d    = wval;
        A_MSCRATCH: mscratch_d = wval;
        A_MEPC:     mepc_d     = wval & ALIGN4;
        A_MCAUSE:   mcause_d   = wval;
        // Writing one half freezes the other half for this cycle
        A_MCYCLE:   mcycle_d   = {mcycle_q[63:32], wval};
        A_MCYCLEH:  mcycle_d   = {wval, mcycle_q[31:0]};
        default: ;
      endcase
    end
    if (take_trap) begin
      mepc_d    = pc_in & ALIGN4;
      mcause_d  = {1'b1, cause_code};
      st_mpie_d = st_mie_q;
      st_mie_d  = 1'b0;
    end else if (do_mret) begin
      st_mie_d  = st_mpie_q;
      st_mpie_d = 1'b1;
    end
  end

  // CSR and redirect registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_mie_q      <= 1'b0;
      st_mpie_q     <= 1'b0;
      mie_q         <= '0;
      mip_q         <= '0;
      mtvec_q       <= RESET_MTVEC;
      mscratch_q    <= '0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      mcycle_q      <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      st_mie_q      <= st_mie_d;
      st_mpie_q     <= st_mpie_d;
      mie_q         <= mie_d;
      mip_q         <= mip_d;
      mtvec_q       <= mtvec_d;
      mscratch_q    <= mscratch_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      mcycle_q      <= mcycle_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;

endmodule
